// File: rtl/enemy_formation.sv
// rtl/enemy_formation.sv - marching alien formation: movement FSM, bullet hits, sprite render
//
// Optional feature macro: SPEEDUP_EN (march period shortens as aliens die).
//
// Ports:
//   clk, reset                clock, asynchronous active-high reset
//   h_counter, v_counter      current VGA pixel position
//   bullet_x/y, bullet_valid  player bullet position and in-flight flag
//   R, G, B, pixel_on         registered pixel output, one clk after h/v
//   hit, hit_idx              one-cycle kill pulse and index row*N_COLS+col
//   alive_count               live aliens
//   all_dead, invaded         sticky end-of-game flags
module enemy_formation #(
  parameter int N_COLS   = 8,
  parameter int N_ROWS   = 4,
  parameter int SCALE    = 3,
  parameter int PITCH    = 32,
  parameter int STEP_X   = 4,
  parameter int STEP_Y   = 8,
  parameter int MOVE_DIV = 1000000,
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 639,
  parameter int START_X  = 64,
  parameter int START_Y  = 40,
  parameter int Y_LOSE   = 440,
  localparam int N  = N_ROWS * N_COLS,
  localparam int IW = $clog2(N),
  localparam int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [9:0]    h_counter,
  input  logic [9:0]    v_counter,
  input  logic [9:0]    bullet_x,
  input  logic [9:0]    bullet_y,
  input  logic          bullet_valid,
  output logic [7:0]    R,
  output logic [7:0]    G,
  output logic [7:0]    B,
  output logic          pixel_on,
  output logic          hit,
  output logic [IW-1:0] hit_idx,
  output logic [CW-1:0] alive_count,
  output logic          all_dead,
  output logic          invaded
);

  localparam int CTW = $clog2(MOVE_DIV + 1);

  // 11-bit working constants so sums near X_MAX cannot wrap
  localparam logic [10:0] PITCH_W = 11'(PITCH);
  localparam logic [10:0] BOX_W   = 11'(8 * SCALE);
  localparam logic [10:0] SCALE_W = 11'(SCALE);
  localparam logic [10:0] STEPX_W = 11'(STEP_X);
  localparam logic [10:0] STEPY_W = 11'(STEP_Y);
  localparam logic [10:0] XMIN_W  = 11'(X_MIN);
  localparam logic [10:0] XMAX_W  = 11'(X_MAX);
  localparam logic [10:0] YLOSE_W = 11'(Y_LOSE);
  localparam logic [10:0] NC_W    = 11'(N_COLS);
  localparam logic [10:0] NR_W    = 11'(N_ROWS);
  localparam logic [10:0] N_W     = 11'(N);

  typedef enum logic [2:0] {
    MOVE_R, MOVE_L, DROP_TO_L, DROP_TO_R, CLEARED, INVADED
  } state_t;

  state_t         state;
  logic [N-1:0]   alive;
  logic [10:0]    origin_x, origin_y;
  logic [CTW-1:0] move_cnt;
  logic [CTW-1:0] period_m1;
  logic           tick, frozen;

`ifdef SPEEDUP_EN
  localparam int P2 = ((MOVE_DIV >> 1) > 0) ? (MOVE_DIV >> 1) : 1;
  localparam int P4 = ((MOVE_DIV >> 2) > 0) ? (MOVE_DIV >> 2) : 1;
  localparam int P8 = ((MOVE_DIV >> 3) > 0) ? (MOVE_DIV >> 3) : 1;
  logic [CTW-1:0] period_m1_next;

  // Chosen continuously but only loaded at a counter wrap
  always_comb begin
    if (alive_count == CW'(1))
      period_m1_next = CTW'(P8 - 1);
    else if (alive_count <= CW'(N / 4))
      period_m1_next = CTW'(P4 - 1);
    else if (alive_count <= CW'(N / 2))
      period_m1_next = CTW'(P2 - 1);
    else
      period_m1_next = CTW'(MOVE_DIV - 1);
  end
`else
  assign period_m1 = CTW'(MOVE_DIV - 1);
`endif

  assign tick   = (move_cnt == period_m1);
  assign frozen = (state == CLEARED) || (state == INVADED);

  // Occupancy per column/row, then extreme live column/row indices
  logic [N_COLS-1:0] col_alive;
  logic [N_ROWS-1:0] row_alive;
  logic [10:0]       right_col, left_col, low_row;

  always_comb begin
    col_alive = '0;
    row_alive = '0;
    for (int r = 0; r < N_ROWS; r++)
      for (int c = 0; c < N_COLS; c++)
        if (alive[r*N_COLS+c]) begin
          col_alive[c] = 1'b1;
          row_alive[r] = 1'b1;
        end
  end

  always_comb begin
    right_col = '0;
    left_col  = '0;
    low_row   = '0;
    for (int c = 0; c < N_COLS; c++)
      if (col_alive[c]) right_col = 11'(c);
    for (int c = N_COLS - 1; c >= 0; c--)
      if (col_alive[c]) left_col = 11'(c);
    for (int r = 0; r < N_ROWS; r++)
      if (row_alive[r]) low_row = 11'(r);
  end

  // Edge decisions; right edge is one past the last sprite pixel
  logic [10:0] right_edge, left_edge, y_drop;
  logic        drop_r, drop_l, invade;

  always_comb begin
    right_edge = origin_x + right_col * PITCH_W + BOX_W;
    left_edge  = origin_x + left_col * PITCH_W;
    drop_r     = (right_edge + STEPX_W) > XMAX_W;
    drop_l     = left_edge < (XMIN_W + STEPX_W);
    y_drop     = origin_y + STEPY_W;
    invade     = (y_drop + low_row * PITCH_W + BOX_W) >= YLOSE_W;
  end

  // Bullet to cell mapping; points left of/above the origin are rejected
  // before the subtraction result is trusted
  logic [10:0] b_dx, b_dy, b_col, b_row, b_ox, b_oy, b_idx;
  logic        b_in, hit_now;

  always_comb begin
    b_dx  = {1'b0, bullet_x} - origin_x;
    b_dy  = {1'b0, bullet_y} - origin_y;
    b_col = b_dx / PITCH_W;
    b_row = b_dy / PITCH_W;
    b_ox  = b_dx % PITCH_W;
    b_oy  = b_dy % PITCH_W;
    b_idx = b_row * NC_W + b_col;
    b_in  = ({1'b0, bullet_x} >= origin_x) && ({1'b0, bullet_y} >= origin_y) &&
            (b_col < NC_W) && (b_row < NR_W) && (b_ox < BOX_W) && (b_oy < BOX_W) &&
            (b_idx < N_W);
    hit_now = bullet_valid && !frozen && b_in && alive[b_idx[IW-1:0]];
  end

  // Sprite bitmap, bit 7 is the leftmost pixel
  function automatic logic [7:0] sprite_row(input logic [2:0] r);
    case (r)
      3'd0:    sprite_row = 8'h3C;
      3'd1:    sprite_row = 8'h7E;
      3'd2:    sprite_row = 8'hFF;
      3'd3:    sprite_row = 8'hCF;
      3'd4:    sprite_row = 8'hFF;
      3'd5:    sprite_row = 8'h24;
      3'd6:    sprite_row = 8'h5A;
      default: sprite_row = 8'hA5;
    endcase
  endfunction

  logic [10:0] p_dx, p_dy, p_col, p_row, p_ox, p_oy, p_sx, p_sy, p_idx;
  logic [7:0]  p_bits;
  logic        p_in, pix_now;

  always_comb begin
    p_dx   = {1'b0, h_counter} - origin_x;
    p_dy   = {1'b0, v_counter} - origin_y;
    p_col  = p_dx / PITCH_W;
    p_row  = p_dy / PITCH_W;
    p_ox   = p_dx % PITCH_W;
    p_oy   = p_dy % PITCH_W;
    p_sx   = p_ox / SCALE_W;
    p_sy   = p_oy / SCALE_W;
    p_idx  = p_row * NC_W + p_col;
    p_in   = ({1'b0, h_counter} >= origin_x) && ({1'b0, v_counter} >= origin_y) &&
             (p_col < NC_W) && (p_row < NR_W) && (p_ox < BOX_W) && (p_oy < BOX_W) &&
             (p_sx < 11'd8) && (p_sy < 11'd8) && (p_idx < N_W);
    p_bits  = sprite_row(p_sy[2:0]);
    pix_now = p_in && alive[p_idx[IW-1:0]] && p_bits[3'd7 - p_sx[2:0]];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= MOVE_R;
      alive       <= '1;
      origin_x    <= 11'(START_X);
      origin_y    <= 11'(START_Y);
      move_cnt    <= '0;
`ifdef SPEEDUP_EN
      period_m1   <= CTW'(MOVE_DIV - 1);
`endif
      alive_count <= CW'(N);
      R           <= '0;
      G           <= '0;
      B           <= '0;
      pixel_on    <= 1'b0;
      hit         <= 1'b0;
      hit_idx     <= '0;
      all_dead    <= 1'b0;
      invaded     <= 1'b0;
    end else begin
      pixel_on <= pix_now;
      R        <= pix_now ? 8'hFF : 8'h00;
      G        <= 8'h00;
      B        <= 8'h00;
      hit      <= 1'b0;

      if (!frozen) begin
        move_cnt <= tick ? '0 : move_cnt + CTW'(1);
`ifdef SPEEDUP_EN
        if (tick) period_m1 <= period_m1_next;
`endif
        if (tick) begin
          case (state)
            MOVE_R: if (drop_r) state <= DROP_TO_L;
                    else        origin_x <= origin_x + STEPX_W;
            MOVE_L: if (drop_l) state <= DROP_TO_R;
                    else        origin_x <= origin_x - STEPX_W;
            DROP_TO_L: begin
              origin_y <= y_drop;
              state    <= invade ? INVADED : MOVE_L;
              invaded  <= invade;
            end
            DROP_TO_R: begin
              origin_y <= y_drop;
              state    <= invade ? INVADED : MOVE_R;
              invaded  <= invade;
            end
            default: state <= state;
          endcase
        end

        // Judged against the pre-move origin; overrides the state when it empties the grid
        if (hit_now) begin
          alive[b_idx[IW-1:0]] <= 1'b0;
          alive_count          <= alive_count - CW'(1);
          hit                  <= 1'b1;
          hit_idx              <= b_idx[IW-1:0];
          if (alive_count == CW'(1)) begin
            state    <= CLEARED;
            all_dead <= 1'b1;
            invaded  <= 1'b0;
          end
        end
      end
    end
  end

endmodule
